// File: rtl/crypt_pkg.sv
// crypt_pkg: shared definitions for the crypt unit.
//   - FSM state encoding
//   - decode funct constants for the encrypt / decrypt instructions
//   - default round count and round-counter width
//   - rol32(): 32-bit rotate-left helper
package crypt_pkg;

    localparam int ROUNDS_DEF = 8;
    // Wide enough for round indices 0..15 (ROUNDS up to 16).
    localparam int CNT_W      = 4;

    localparam logic [5:0] FUNCT_ENC = 6'h30;
    localparam logic [5:0] FUNCT_DEC = 6'h31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } crypt_state_e;

    function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
        // Shifting the doubled word and keeping its top half yields the rotation.
        return 32'(({x, x} << (n % 32)) >> 32);
    endfunction

    // Decode helper: funct field to the mode bit (1 = decrypt).
    function automatic logic funct_is_decrypt(input logic [5:0] funct);
        return (funct == FUNCT_DEC) && (funct != FUNCT_ENC);
    endfunction

endpackage

// File: rtl/crypt_if.sv
// crypt_if: CPU <-> crypt unit signal bundle.
//   start   : crypt instruction in decode
//   mode    : 0 = encrypt, 1 = decrypt
//   data_in : rs operand
//   key     : rt operand
//   stall   : freezes PC and register-file write while high
//   busy    : unit is not idle
//   done    : one-cycle pulse, result valid for write-back
//   result  : crypt output
// master = CPU side, slave = crypt unit side.
interface crypt_if;
    logic        start;
    logic        mode;
    logic [31:0] data_in;
    logic [31:0] key;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (output start, mode, data_in, key,
                    input  stall, busy, done, result);
    modport slave  (input  start, mode, data_in, key,
                    output stall, busy, done, result);
endinterface

// File: rtl/crypt_round.sv
// crypt_round: one combinational Feistel round on a 16/16-bit split.
//   l_i, r_i : current halves
//   k_i      : round key
//   mode_i   : 0 = encrypt round, 1 = decrypt round
//   l_o, r_o : next halves
// F(x,k) = ((x rol 3) ^ k) + x, modulo 2^16.
// Macro CRYPT_DECRYPT_EN: when undefined only the encrypt round is built
// and mode_i is ignored.
module crypt_round (
    input  logic [15:0] l_i,
    input  logic [15:0] r_i,
    input  logic [15:0] k_i,
    input  logic        mode_i,
    output logic [15:0] l_o,
    output logic [15:0] r_o
);

    function automatic logic [15:0] f_fn(input logic [15:0] x, input logic [15:0] k);
        return ({x[12:0], x[15:13]} ^ k) + x;
    endfunction

`ifdef CRYPT_DECRYPT_EN
    always_comb begin
        if (mode_i) begin
            // Inverse of the encrypt round: F is applied to the left half.
            l_o = r_i ^ f_fn(l_i, k_i);
            r_o = l_i;
        end else begin
            l_o = r_i;
            r_o = l_i ^ f_fn(r_i, k_i);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign l_o = r_i;
    assign r_o = l_i ^ f_fn(r_i, k_i);
`endif

endmodule

// File: rtl/crypt_unit.sv
// crypt_unit: multi-cycle Feistel encrypt/decrypt co-processor.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : crypt_if.slave (start/mode/data_in/key in; stall/busy/done/result out)
// Parameter ROUNDS (1..16): Feistel round count.
// One round per cycle; start accepted in IDLE at cycle t gives done at t+ROUNDS+1.
// Macro CRYPT_DECRYPT_EN: enables the decrypt datapath. When undefined, a
// decrypt request bypasses straight to DONE with result = data_in.
module crypt_unit
    import crypt_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    crypt_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    crypt_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      l_q, l_d, r_q, r_d;
    logic [31:0]      key_q, key_d;
    logic [31:0]      result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [15:0]      l_nxt, r_nxt;
    logic             rnd_mode;
    logic             dec_bypass;
    logic [31:0]      key_init;
    logic [31:0]      key_step;

    // The key register always holds the current round key in [15:0]:
    // encrypt walks it left by 4 per round, decrypt starts at the last
    // round's rotation and walks it right by 4 (rol 28).
`ifdef CRYPT_DECRYPT_EN
    localparam int unsigned DEC_ROT = (4 * (ROUNDS - 1)) % 32;

    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (state_q == ST_IDLE && bus.start) mode_d = bus.mode;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= 1'b0;
        else        mode_q <= mode_d;
    end

    assign dec_bypass = 1'b0;
    assign key_init   = bus.mode ? rol32(bus.key, DEC_ROT) : bus.key;
    assign key_step   = mode_q ? rol32(key_q, 28) : rol32(key_q, 4);
    assign rnd_mode   = mode_q;
`else
    assign dec_bypass = bus.mode;
    assign key_init   = bus.key;
    assign key_step   = rol32(key_q, 4);
    assign rnd_mode   = 1'b0;
`endif

    crypt_round u_round (
        .l_i    (l_q),
        .r_i    (r_q),
        .k_i    (key_q[15:0]),
        .mode_i (rnd_mode),
        .l_o    (l_nxt),
        .r_o    (r_nxt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        l_d      = l_q;
        r_d      = r_q;
        key_d    = key_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (dec_bypass) begin
                        result_d = bus.data_in;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        l_d     = bus.data_in[31:16];
                        r_d     = bus.data_in[15:0];
                        key_d   = key_init;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                l_d   = l_nxt;
                r_d   = r_nxt;
                key_d = key_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // result only moves here, so it holds through DONE/IDLE.
                    result_d = {l_nxt, r_nxt};
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            l_q      <= '0;
            r_q      <= '0;
            key_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            l_q      <= l_d;
            r_q      <= r_d;
            key_q    <= key_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Dropping stall in DONE lets the CPU retire the instruction that cycle.
    assign bus.stall  = bus.start && (state_q != ST_DONE);
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_crypt_unit.sv
// tb_crypt_unit: directed bench for crypt_unit (ROUNDS=8) plus a ROUNDS=1
// instance pinned by hand-computed single-round results.
module tb_crypt_unit;

    localparam int R = 8;
`ifdef CRYPT_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crypt_if bus ();
    crypt_if bus1 ();

    crypt_unit #(.ROUNDS(R)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    crypt_unit #(.ROUNDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_k(input logic [31:0] k, input int i);
        logic [63:0] w;
        w = {32'h0, k} << ((4 * i) % 32);
        return w[15:0] | w[47:32];
    endfunction

    function automatic logic [15:0] ref_f(input logic [15:0] x, input logic [15:0] k);
        int rot, s;
        rot = ((int'(x) * 8) % 65536) + (int'(x) / 8192);
        s   = (rot ^ int'(k)) + int'(x);
        return 16'(s % 65536);
    endfunction

    function automatic logic [31:0] ref_crypt(input logic [31:0] d, input logic [31:0] k,
                                              input bit dec, input int nr);
        logic [15:0] l, r, t;
        l = d[31:16];
        r = d[15:0];
`ifdef CRYPT_DECRYPT_EN
        if (dec) begin
            for (int i = nr - 1; i >= 0; i--) begin
                t = l; l = r ^ ref_f(l, ref_k(k, i)); r = t;
            end
            return {l, r};
        end
`else
        if (dec) return d;
`endif
        for (int i = 0; i < nr; i++) begin
            t = r; r = l ^ ref_f(r, ref_k(k, i)); l = t;
        end
        return {l, r};
    endfunction

    // Transaction-level expectation: accepted request -> done cycle + value.
    int          cyc = 0;
    bit          pend = 1'b0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    logic [31:0] pend_res = '0;
    logic [31:0] exp_res = '0;
    bit          ed, eb;

    initial forever begin
        @(posedge clk);
        if (rst_n && bus.start && (!pend || cyc > done_cyc)) begin
            pend     = 1'b1;
            acc_cyc  = cyc;
            done_cyc = cyc + ((bus.mode && !DEC_EN) ? 1 : R + 1);
            pend_res = ref_crypt(bus.data_in, bus.key, bus.mode, R);
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend    = 1'b0;
            exp_res = '0;
        end
        ed = pend && (cyc == done_cyc);
        eb = pend && (cyc > acc_cyc) && (cyc <= done_cyc);
        if (ed) exp_res = pend_res;
        chk("done",  32'(bus.done),  32'(ed));
        chk("busy",  32'(bus.busy),  32'(eb));
        chk("stall", 32'(bus.stall), 32'(bus.start && !ed));
        if (!eb || ed) chk("result", bus.result, exp_res);
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input string nm, input logic [31:0] d, input logic [31:0] k,
                          input logic m, input bit tog, input bit keep,
                          output logic [31:0] res, output int lat, output int st);
        int t;
        bit seen;
        @(posedge clk);
        #1;
        bus.data_in = d;
        bus.key     = k;
        bus.mode    = m;
        bus.start   = 1'b1;
        t    = cyc;
        seen = 1'b0;
        lat  = -1;
        st   = 0;
        res  = 'x;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.stall) st++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - t;
                res  = bus.result;
            end else begin
                @(posedge clk);
                #1;
                if (tog) bus.start = ~bus.start;
            end
        end
        if (!seen) begin
            vectors++;
            errors++;
            $display("FAIL %s: done not seen within 40 cycles", nm);
        end
        if (!keep) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    logic [31:0] d1 [2] = '{32'h00010002, 32'h0000FFFF};
    logic [31:0] k1 [2] = '{32'hABCD0001, 32'h00000000};
    logic [31:0] e1 [2] = '{32'h00020012, 32'hFFFFFFFE};

    initial begin
        logic [31:0] res, enc, exp_v;
        int lat, st, pulses, t1;

        bus.start = 1'b0;  bus.mode = 1'b0;  bus.data_in = '0;  bus.key = '0;
        bus1.start = 1'b0; bus1.mode = 1'b0; bus1.data_in = '0; bus1.key = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_done",   32'(bus.done), 32'd0);
        chk("rst_result", bus.result,    32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed single rounds pin the model.
        chk("pin_model_a", ref_crypt(32'h00010002, 32'hABCD0001, 1'b0, 1), 32'h00020012);
        chk("pin_model_b", ref_crypt(32'h0000FFFF, 32'h00000000, 1'b0, 1), 32'hFFFFFFFE);

        // All-zero encrypt; start held until done.
        run_op("zero", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, res, lat, st);
        chk("zero_res", res, 32'h0);
        chk("zero_lat", 32'(lat), 32'd9);
        chk("zero_stall_cycles", 32'(st), 32'd9);

        // Known plaintext, then decrypt of its ciphertext.
        run_op("enc", 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, enc, lat, st);
        chk("enc_lat", 32'(lat), 32'(R + 1));
        run_op("dec", enc, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, res, lat, st);
`ifdef CRYPT_DECRYPT_EN
        chk("roundtrip", res, 32'h12345678);
        chk("dec_lat", 32'(lat), 32'(R + 1));
`else
        chk("dec_bypass_res", res, enc);
        chk("dec_bypass_lat", 32'(lat), 32'd1);
`endif

        // Start toggling during RUN must not matter.
        run_op("toggle", 32'hA5A55A5A, 32'h0F1E2D3C, 1'b0, 1'b1, 1'b0, res, lat, st);
        chk("toggle_lat", 32'(lat), 32'(R + 1));
        chk("toggle_res", res, ref_crypt(32'hA5A55A5A, 32'h0F1E2D3C, 1'b0, R));

        // Back-to-back: next start already high in the DONE cycle.
        run_op("b2b_a", 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, res, lat, st);
        chk("b2b_a_res", res, ref_crypt(32'h00000001, 32'hFFFFFFFF, 1'b0, R));
        run_op("b2b_b", 32'h80008000, 32'h76543210, 1'b0, 1'b0, 1'b0, res, lat, st);
        chk("b2b_b_lat", 32'(lat), 32'(R + 1));
        chk("b2b_b_res", res, ref_crypt(32'h80008000, 32'h76543210, 1'b0, R));

        // Decrypt of 0xCAFEBABE.
        run_op("cafe", 32'hCAFEBABE, 32'h13579BDF, 1'b1, 1'b0, 1'b0, res, lat, st);
`ifdef CRYPT_DECRYPT_EN
        chk("cafe_res", res, ref_crypt(32'hCAFEBABE, 32'h13579BDF, 1'b1, R));
        chk("cafe_lat", 32'(lat), 32'(R + 1));
`else
        chk("cafe_res", res, 32'hCAFEBABE);
        chk("cafe_lat", 32'(lat), 32'd1);
        chk("cafe_stall_cycles", 32'(st), 32'd1);
`endif

        // Reset during round 4.
        @(posedge clk);
        #1;
        bus.data_in = 32'h0BADF00D; bus.key = 32'h11223344; bus.mode = 1'b0; bus.start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        #1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("rst_mid_busy",   32'(bus.busy), 32'd0);
        chk("rst_mid_done",   32'(bus.done), 32'd0);
        chk("rst_mid_result", bus.result,    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("no_resume_done", 32'(pulses), 32'd0);
        chk("no_resume_busy", 32'(bus.busy), 32'd0);
        run_op("after_rst", 32'h0BADF00D, 32'h11223344, 1'b0, 1'b0, 1'b0, res, lat, st);
        chk("after_rst_lat", 32'(lat), 32'(R + 1));
        chk("after_rst_res", res, ref_crypt(32'h0BADF00D, 32'h11223344, 1'b0, R));

        // ROUNDS=1 instance against hand-computed values.
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            bus1.data_in = d1[n]; bus1.key = k1[n]; bus1.mode = 1'b0; bus1.start = 1'b1;
            t1  = cyc;
            lat = -1;
            exp_v = 'x;
            for (int c = 0; c < 10 && lat < 0; c++) begin
                @(negedge clk);
                if (bus1.done) begin
                    lat   = cyc - t1;
                    exp_v = bus1.result;
                end
            end
            @(posedge clk);
            #1 bus1.start = 1'b0;
            chk("r1_lat", 32'(lat), 32'd2);
            chk("r1_res", exp_v, e1[n]);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/crypt_unit.md
CRYPT_UNIT -- requirements
Module: crypt_unit

Interface
REQ-001 SHALL have parameter ROUNDS, default 8, which is the Feistel round count; legal range is 1..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a crypt instruction is in decode (opcode 0x00, funct 0x30 or 0x31).
REQ-005 SHALL have port mode, input, 1 bit: 0 = encrypt (funct 0x30), 1 = decrypt (funct 0x31).
REQ-006 SHALL have port data_in, input, 32 bits: rs operand.
REQ-007 SHALL have port key, input, 32 bits: rt operand.
REQ-008 SHALL have port stall, output, 1 bit: freezes PC and the register-file write while high.
REQ-009 SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; result valid for the write-back select 2'b11.
REQ-011 SHALL have port result, output, 32 bits: crypt output.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, latch data_in, key and mode, clear the round counter, and go to RUN.
REQ-014 SHALL ignore start while in RUN or DONE.
REQ-015 SHALL, in RUN, execute exactly one round per cycle, moving to DONE after the round with index ROUNDS-1.
REQ-016 SHALL, in DONE, assert done=1 and return to IDLE on the next cycle.
REQ-017 SHALL drive stall = start AND (state != DONE), combinationally, so the CPU advances at the end of the DONE cycle.
REQ-018 SHALL give latency ROUNDS+1 cycles: start sampled in IDLE at cycle t gives done at cycle t+ROUNDS+1.
REQ-019 SHALL hold result stable from DONE until the next accepted start.
REQ-020 SHALL form state {L,R} from the latched data as L=[31:16], R=[15:0].
REQ-021 SHALL compute round key k_i = bits [15:0] of (key rotated left by 4*i mod 32).
REQ-022 SHALL compute F(x,k) = ((x rol 3) XOR k) + x, all 16-bit, with the sum taken modulo 2^16.
REQ-023 SHALL, for encrypt, apply i = 0..ROUNDS-1 as L' = R, R' = L XOR F(R,k_i).
REQ-024 SHALL, for decrypt, apply i = ROUNDS-1..0 as R' = L, L' = R XOR F(L,k_i).
REQ-025 SHALL set result = {L,R} after the final round.
REQ-026 SHALL treat start asserted in the DONE cycle by the next instruction as a new request, accepted in the following IDLE cycle.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-RUN, immediately force state=IDLE, counter=0, result=0, done=0 and busy=0.
REQ-028 SHALL not resume an interrupted operation after rst_n deasserts.

Configuration
REQ-029 SHALL implement decrypt per REQ-024 when CRYPT_DECRYPT_EN is defined.
REQ-030 SHALL, when CRYPT_DECRYPT_EN is undefined, send start with mode=1 directly IDLE->DONE with result=data_in (latency 1, stall high one cycle) and build no decrypt datapath.

Structure
REQ-031 SHALL place the state encoding, the funct constants 6'h30 and 6'h31, and the default ROUNDS in a shared package crypt_pkg.
REQ-032 SHALL implement one round as a combinational sub-module crypt_round with inputs L, R, k_i and mode, and outputs L' and R'.

Verification
REQ-033 SHALL cover: data_in=0, key=0, encrypt -> result=0x00000000, done at cycle t+9.
REQ-034 SHALL cover: encrypt 0x12345678 with key 0xDEADBEEF, then decrypt the output with the same key -> 0x12345678.
REQ-035 SHALL cover: start held high from cycle t -> stall=1 for cycles t..t+8, stall=0 at t+9, done=1 only at t+9.
REQ-036 SHALL cover: rst_n pulsed low during round 4 -> busy=0, result=0, done never pulses; a new start afterwards completes normally.
REQ-037 SHALL cover: start toggling while in RUN -> no effect on result or latency.
REQ-038 SHALL cover: build without CRYPT_DECRYPT_EN, decrypt of 0xCAFEBABE -> result=0xCAFEBABE, done at t+1.
